// File: rtl/store_rs_queue_pkg.sv
// Shared constants for the store reservation station queue: default widths
// and the operand slot names used to index an entry's V/Q registers.
package store_rs_queue_pkg;

    localparam int DEPTH_DEF     = 4;
    localparam int WORD_SIZE_DEF = 32;
    localparam int RB_INDEX_DEF  = 4;
    localparam int RB_SIZE_DEF   = 8;

    // Vi = store data, Vj = base, Vk = offset/register
    typedef enum logic [1:0] {
        OP_I = 2'd0,
        OP_J = 2'd1,
        OP_K = 2'd2
    } op_e;

endpackage

// File: rtl/store_rs_queue_if.sv
// Dispatch-side issue port and storer-side result port of the store RS queue.
// master = dispatch/storer environment, slave = the reservation station.
interface store_rs_queue_if
    import store_rs_queue_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int RB_INDEX  = RB_INDEX_DEF
);

    // Both ports transfer on a posedge where valid && ready; a producer holds
    // valid and a stable payload until it is taken. issue_ready is derived from
    // the registered occupancy only, never from a same-cycle free.
    logic                 issue_valid;
    logic                 issue_ready;
    logic [RB_INDEX-1:0]  issue_rb_index;
    logic [WORD_SIZE-1:0] issue_vi;
    logic [WORD_SIZE-1:0] issue_vj;
    logic [WORD_SIZE-1:0] issue_vk;
    logic [RB_INDEX-1:0]  issue_qi;
    logic [RB_INDEX-1:0]  issue_qj;
    logic [RB_INDEX-1:0]  issue_qk;

    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] out_addr;
    logic [WORD_SIZE-1:0] out_data;
    logic [RB_INDEX-1:0]  out_rb_index;

    modport master (
        output issue_valid, issue_rb_index, issue_vi, issue_vj, issue_vk,
               issue_qi, issue_qj, issue_qk, out_ready,
        input  issue_ready, out_valid, out_addr, out_data, out_rb_index
    );

    modport slave (
        input  issue_valid, issue_rb_index, issue_vi, issue_vj, issue_vk,
               issue_qi, issue_qj, issue_qk, out_ready,
        output issue_ready, out_valid, out_addr, out_data, out_rb_index
    );

endinterface

// File: rtl/store_rs_queue_entry.sv
// One store RS entry: V/Q operand registers with CDB snooping (also applied to
// the operands arriving with an allocation) and a registered-state ready flag.
module store_rs_entry
    import store_rs_queue_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int RB_INDEX  = RB_INDEX_DEF,
    parameter int RB_SIZE   = RB_SIZE_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         alloc,
    input  logic                         free,
    input  logic [RB_INDEX-1:0]          in_rb_index,
    input  logic [WORD_SIZE-1:0]         in_vi,
    input  logic [WORD_SIZE-1:0]         in_vj,
    input  logic [WORD_SIZE-1:0]         in_vk,
    input  logic [RB_INDEX-1:0]          in_qi,
    input  logic [RB_INDEX-1:0]          in_qj,
    input  logic [RB_INDEX-1:0]          in_qk,
    input  logic [WORD_SIZE*RB_SIZE-1:0] cdb_data,
    input  logic [RB_SIZE-1:0]           cdb_valid,
    output logic                         valid,
    output logic                         ready,
    output logic [RB_INDEX-1:0]          rb_index,
    output logic [WORD_SIZE-1:0]         vi,
    output logic [WORD_SIZE-1:0]         vj,
    output logic [WORD_SIZE-1:0]         vk
);

    localparam logic [RB_INDEX-1:0] READY = '1;
    localparam int TAGS = 1 << RB_INDEX;

    // Zero-extended to every encodable tag, so tags >= RB_SIZE (and READY) never hit.
    logic [TAGS-1:0]      cdb_valid_ext;
    logic [WORD_SIZE-1:0] v_q[3], v_src[3], v_nxt[3];
    logic [RB_INDEX-1:0]  q_q[3], q_src[3], q_nxt[3];

    assign cdb_valid_ext = TAGS'(cdb_valid);

    always_comb begin
        v_src[OP_I] = alloc ? in_vi : v_q[OP_I];
        v_src[OP_J] = alloc ? in_vj : v_q[OP_J];
        v_src[OP_K] = alloc ? in_vk : v_q[OP_K];
        q_src[OP_I] = alloc ? in_qi : q_q[OP_I];
        q_src[OP_J] = alloc ? in_qj : q_q[OP_J];
        q_src[OP_K] = alloc ? in_qk : q_q[OP_K];
        for (int k = 0; k < 3; k++) begin
            v_nxt[k] = v_src[k];
            q_nxt[k] = q_src[k];
            if (q_src[k] != READY && cdb_valid_ext[q_src[k]]) begin
                q_nxt[k] = READY;
                for (int n = 0; n < RB_SIZE; n++) begin
                    if (q_src[k] == RB_INDEX'(n)) v_nxt[k] = cdb_data[n*WORD_SIZE +: WORD_SIZE];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            valid    <= 1'b0;
            rb_index <= READY;
            for (int k = 0; k < 3; k++) begin
                v_q[k] <= '0;
                q_q[k] <= READY;
            end
        end else begin
            if (alloc) begin
                valid    <= 1'b1;
                rb_index <= in_rb_index;
            end else if (free) begin
                valid <= 1'b0;
            end
            if (alloc || valid) begin
                for (int k = 0; k < 3; k++) begin
                    v_q[k] <= v_nxt[k];
                    q_q[k] <= q_nxt[k];
                end
            end
        end
    end

    assign ready = valid && (q_q[OP_I] == READY) && (q_q[OP_J] == READY) && (q_q[OP_K] == READY);
    assign vi    = v_q[OP_I];
    assign vj    = v_q[OP_J];
    assign vk    = v_q[OP_K];

endmodule

// File: rtl/store_rs_queue.sv
// Multi-entry store reservation station: allocation, age tracking and a
// one-entry output skid stage. Define STORE_RS_OOO_EN for oldest-ready selection.
module store_rs_queue
    import store_rs_queue_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int RB_INDEX  = RB_INDEX_DEF,
    parameter int RB_SIZE   = RB_SIZE_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    store_rs_queue_if.slave              rs,
    input  logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_data,
    input  logic [RB_SIZE-1:0]           CDB_data_valid,
    output logic                         busy,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [RB_INDEX-1:0] READY = '1;

    logic [DEPTH-1:0]     e_valid, e_ready, e_alloc, e_free;
    logic [RB_INDEX-1:0]  e_rb[DEPTH];
    logic [WORD_SIZE-1:0] e_vi[DEPTH], e_vj[DEPTH], e_vk[DEPTH];
    logic [AW-1:0]        age[DEPTH];

    logic [AW-1:0]        free_idx, sel_idx, sel_age, new_age;
    logic                 sel_found, do_alloc, do_load;

    logic                 out_valid_r;
    logic [WORD_SIZE-1:0] out_addr_r, out_data_r;
    logic [RB_INDEX-1:0]  out_rb_r;

    assign rs.issue_ready  = (count != FULL);
    assign rs.out_valid    = out_valid_r;
    assign rs.out_addr     = out_addr_r;
    assign rs.out_data     = out_data_r;
    assign rs.out_rb_index = out_rb_r;
    assign busy            = (count != '0);

    assign do_alloc = rs.issue_valid && rs.issue_ready && !flush;
    assign do_load  = sel_found && (!out_valid_r || rs.out_ready) && !flush;
    // The new entry is youngest after this cycle's compaction.
    assign new_age  = do_load ? count[AW-1:0] - 1'b1 : count[AW-1:0];

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!e_valid[i]) free_idx = AW'(i);
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef STORE_RS_OOO_EN
            if (e_ready[i] && (!sel_found || age[i] < sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = AW'(i);
                sel_age   = age[i];
            end
`else
            if (e_ready[i] && age[i] == '0) begin
                sel_found = 1'b1;
                sel_idx   = AW'(i);
            end
`endif
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        assign e_alloc[g] = do_alloc && (free_idx == AW'(g));
        assign e_free[g]  = do_load && (sel_idx == AW'(g));

        store_rs_entry #(
            .WORD_SIZE (WORD_SIZE),
            .RB_INDEX  (RB_INDEX),
            .RB_SIZE   (RB_SIZE)
        ) u_entry (
            .clk         (clk),
            .reset       (reset),
            .flush       (flush),
            .alloc       (e_alloc[g]),
            .free        (e_free[g]),
            .in_rb_index (rs.issue_rb_index),
            .in_vi       (rs.issue_vi),
            .in_vj       (rs.issue_vj),
            .in_vk       (rs.issue_vk),
            .in_qi       (rs.issue_qi),
            .in_qj       (rs.issue_qj),
            .in_qk       (rs.issue_qk),
            .cdb_data    (CDB_data_data),
            .cdb_valid   (CDB_data_valid),
            .valid       (e_valid[g]),
            .ready       (e_ready[g]),
            .rb_index    (e_rb[g]),
            .vi          (e_vi[g]),
            .vj          (e_vj[g]),
            .vk          (e_vk[g])
        );
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!reset || flush) begin
                age[i] <= '0;
            end else if (e_alloc[i]) begin
                age[i] <= new_age;
            end else if (do_load && e_valid[i] && age[i] > sel_age) begin
                age[i] <= age[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            count <= '0;
        end else begin
            count <= count + {{AW{1'b0}}, do_alloc} - {{AW{1'b0}}, do_load};
        end
    end

    // Skid stage: refills in the same cycle its current content is accepted.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            out_valid_r <= 1'b0;
            out_addr_r  <= '0;
            out_data_r  <= '0;
            out_rb_r    <= READY;
        end else if (do_load) begin
            out_valid_r <= 1'b1;
            out_addr_r  <= e_vj[sel_idx] + e_vk[sel_idx];
            out_data_r  <= e_vi[sel_idx];
            out_rb_r    <= e_rb[sel_idx];
        end else if (rs.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_store_rs_queue.sv
// Self-checking bench for store_rs_queue: directed scenarios plus randomized
// traffic against a program-order queue model of the reservation station.
module tb_store_rs_queue;
  import store_rs_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int W = 32;
  localparam int RI = 4;
  localparam int RS = 8;
  localparam int TW = $clog2(RS);
  localparam logic [RI-1:0] READY = '1;
`ifdef STORE_RS_OOO_EN
  localparam int EXP_EARLY = 1;
  localparam logic [RI-1:0] EXP_FIRST = 4'd10;
`else
  localparam int EXP_EARLY = 0;
  localparam logic [RI-1:0] EXP_FIRST = 4'd9;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic [W*RS-1:0] cdb_data = '0;
  logic [RS-1:0] cdb_valid = '0;
  logic busy;
  logic [$clog2(DEPTH):0] count;

  store_rs_queue_if #(.WORD_SIZE(W), .RB_INDEX(RI)) rs();

  store_rs_queue #(.DEPTH(DEPTH), .WORD_SIZE(W), .RB_INDEX(RI), .RB_SIZE(RS)) dut (
    .clk(clk), .reset(reset), .flush(flush), .rs(rs),
    .CDB_data_data(cdb_data), .CDB_data_valid(cdb_valid),
    .busy(busy), .count(count)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: entries in program order, plus the output register
  typedef struct packed {
    logic [RI-1:0] rb;
    logic [RI-1:0] qi, qj, qk;
    logic [W-1:0]  vi, vj, vk;
  } ment_t;

  ment_t mq[$];
  logic m_valid;
  logic [W-1:0] m_addr, m_data;
  logic [RI-1:0] m_rb;
  logic [RI-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  function automatic logic [RI+W-1:0] res(input logic [RI-1:0] q, input logic [W-1:0] v);
    if (q != READY && int'(q) < RS && cdb_valid[q[TW-1:0]]) return {READY, cdb_data[int'(q)*W +: W]};
    return {q, v};
  endfunction

  function automatic ment_t snoop_ent(input ment_t e);
    ment_t r = e;
    {r.qi, r.vi} = res(e.qi, e.vi);
    {r.qj, r.vj} = res(e.qj, e.vj);
    {r.qk, r.vk} = res(e.qk, e.vk);
    return r;
  endfunction

  function automatic bit all_ready(input ment_t e);
    return e.qi == READY && e.qj == READY && e.qk == READY;
  endfunction

  task automatic model_step();
    int sel;
    int pre;
    ment_t e;
    if (!reset || flush) begin
      mq.delete();
      m_valid = 1'b0; m_addr = '0; m_data = '0; m_rb = READY;
      return;
    end
    pre = mq.size();
    sel = -1;
`ifdef STORE_RS_OOO_EN
    for (int i = 0; i < mq.size(); i++) if (sel < 0 && all_ready(mq[i])) sel = i;
`else
    if (mq.size() > 0 && all_ready(mq[0])) sel = 0;
`endif
    if (sel >= 0 && (!m_valid || rs.out_ready)) begin
      m_valid = 1'b1;
      m_addr = mq[sel].vj + mq[sel].vk;
      m_data = mq[sel].vi;
      m_rb = mq[sel].rb;
      mq.delete(sel);
    end else if (m_valid && rs.out_ready) begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < mq.size(); i++) mq[i] = snoop_ent(mq[i]);
    if (rs.issue_valid && pre < DEPTH) begin
      e.rb = rs.issue_rb_index;
      e.vi = rs.issue_vi; e.vj = rs.issue_vj; e.vk = rs.issue_vk;
      e.qi = rs.issue_qi; e.qj = rs.issue_qj; e.qk = rs.issue_qk;
      mq.push_back(snoop_ent(e));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // driver tasks
  task automatic issue(input logic [RI-1:0] rb, input logic [W-1:0] vi, vj, vk,
                       input logic [RI-1:0] qi, qj, qk);
    rs.issue_valid = 1'b1; rs.issue_rb_index = rb;
    rs.issue_vi = vi; rs.issue_vj = vj; rs.issue_vk = vk;
    rs.issue_qi = qi; rs.issue_qj = qj; rs.issue_qk = qk;
  endtask

  task automatic idle();
    rs.issue_valid = 1'b0;
  endtask

  function automatic logic [RI-1:0] rand_tag();
    if ($urandom_range(0, 1) == 0) return READY;
    return RI'($urandom_range(0, RS - 1));
  endfunction

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; idle(); rs.out_ready = 1'b1;
    tick(); tick();
    n_checks++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", busy); else n_pass++;
    n_checks++; if (rs.out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b exp 0", rs.out_valid); else n_pass++;
    n_checks++; if (rs.out_addr !== 32'h0) $display("FAIL reset_out_addr got %0h exp 0", rs.out_addr); else n_pass++;
    n_checks++; if (rs.out_data !== 32'h0) $display("FAIL reset_out_data got %0h exp 0", rs.out_data); else n_pass++;
    n_checks++; if (rs.out_rb_index !== READY) $display("FAIL reset_out_rb got %0h exp %0h", rs.out_rb_index, READY); else n_pass++;
    n_checks++; if (rs.issue_ready !== 1'b1) $display("FAIL reset_issue_ready got %0b exp 1", rs.issue_ready); else n_pass++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_all_ready();
    issue(4'd3, 32'hDEAD, 32'h100, 32'h8, READY, READY, READY);
    tick(); idle();
    n_checks++; if (rs.out_valid !== 1'b0) $display("FAIL ready_early got %0b exp 0", rs.out_valid); else n_pass++;
    n_checks++; if (count !== 3'd1) $display("FAIL ready_count got %0d exp 1", count); else n_pass++;
    tick();
    n_checks++; if (rs.out_valid !== 1'b1) $display("FAIL ready_valid got %0b exp 1", rs.out_valid); else n_pass++;
    n_checks++; if (rs.out_addr !== 32'h108) $display("FAIL ready_addr got %0h exp 108", rs.out_addr); else n_pass++;
    n_checks++; if (rs.out_data !== 32'hDEAD) $display("FAIL ready_data got %0h exp dead", rs.out_data); else n_pass++;
    n_checks++; if (rs.out_rb_index !== 4'd3) $display("FAIL ready_rb got %0h exp 3", rs.out_rb_index); else n_pass++;
    tick();
    n_checks++; if (rs.out_valid !== 1'b0) $display("FAIL ready_drop got %0b exp 0", rs.out_valid); else n_pass++;
  endtask

  task automatic test_cdb_pending();
    issue(4'd6, 32'h55, 32'h0, 32'h4, READY, 4'd5, READY);
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (rs.out_valid !== 1'b0) $display("FAIL pend_wait%0d got %0b exp 0", i, rs.out_valid); else n_pass++;
    end
    cdb_valid[5] = 1'b1; cdb_data[5*W +: W] = 32'h2000;
    tick(); cdb_valid = '0;
    n_checks++; if (rs.out_valid !== 1'b0) $display("FAIL pend_capture got %0b exp 0", rs.out_valid); else n_pass++;
    tick();
    n_checks++; if (rs.out_valid !== 1'b1) $display("FAIL pend_valid got %0b exp 1", rs.out_valid); else n_pass++;
    n_checks++; if (rs.out_addr !== 32'h2004) $display("FAIL pend_addr got %0h exp 2004", rs.out_addr); else n_pass++;
    n_checks++; if (rs.out_rb_index !== 4'd6) $display("FAIL pend_rb got %0h exp 6", rs.out_rb_index); else n_pass++;
    tick();
  endtask

  task automatic test_issue_capture();
    issue(4'd7, 32'h0, 32'h40, 32'h0, 4'd2, READY, READY);
    cdb_valid[2] = 1'b1; cdb_data[2*W +: W] = 32'hBEEF;
    tick(); idle(); cdb_valid = '0;
    tick();
    n_checks++; if (rs.out_valid !== 1'b1) $display("FAIL cap_valid got %0b exp 1", rs.out_valid); else n_pass++;
    n_checks++; if (rs.out_data !== 32'hBEEF) $display("FAIL cap_data got %0h exp beef", rs.out_data); else n_pass++;
    n_checks++; if (rs.out_addr !== 32'h40) $display("FAIL cap_addr got %0h exp 40", rs.out_addr); else n_pass++;
    tick();
  endtask

  task automatic test_full_stall();
    int budget;
    logic [RI-1:0] exp_rb;
    exp_q.delete();
    rs.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      issue(RI'(i + 1), $urandom, $urandom, $urandom, READY, READY, READY);
      n_checks++;
      if (rs.issue_ready !== (mq.size() != DEPTH)) $display("FAIL full_issue_ready%0d got %0b exp %0b", i, rs.issue_ready, mq.size() != DEPTH);
      else n_pass++;
      if (mq.size() < DEPTH) exp_q.push_back(RI'(i + 1));
      tick();
    end
    idle();
    n_checks++; if (count !== 3'd4) $display("FAIL full_count got %0d exp 4", count); else n_pass++;
    n_checks++; if (rs.issue_ready !== 1'b0) $display("FAIL full_ready got %0b exp 0", rs.issue_ready); else n_pass++;
    n_checks++; if (exp_q.size() != 5) $display("FAIL full_accepted got %0d exp 5", exp_q.size()); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (rs.out_valid !== 1'b1 || rs.out_rb_index !== exp_q[0] || rs.out_addr !== m_addr || rs.out_data !== m_data)
        $display("FAIL hold%0d got v=%0b rb=%0h addr=%0h exp v=1 rb=%0h addr=%0h", i, rs.out_valid, rs.out_rb_index, rs.out_addr, exp_q[0], m_addr);
      else n_pass++;
    end
    rs.out_ready = 1'b1;
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      if (rs.out_valid) begin
        exp_rb = exp_q.pop_front();
        n_checks++; if (rs.out_rb_index !== exp_rb) $display("FAIL drain_rb got %0h exp %0h", rs.out_rb_index, exp_rb); else n_pass++;
      end
      tick();
      n_checks++; if (count !== 3'(mq.size())) $display("FAIL drain_count got %0d exp %0d", count, mq.size()); else n_pass++;
      budget--;
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL drain_timeout got %0d left exp 0", exp_q.size()); else n_pass++;
    n_checks++; if (count !== 3'd0 || busy !== 1'b0) $display("FAIL drain_empty got count=%0d busy=%0b exp 0 0", count, busy); else n_pass++;
    n_checks++; if (rs.out_valid !== 1'b0) $display("FAIL drain_out_valid got %0b exp 0", rs.out_valid); else n_pass++;
  endtask

  task automatic test_in_order();
    logic [RI-1:0] got[$];
    rs.out_ready = 1'b1;
    issue(4'd9, 32'h11, 32'h0, 32'h10, READY, 4'd1, READY);
    tick();
    issue(4'd10, 32'h22, 32'h200, 32'h20, READY, READY, READY);
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (rs.out_valid !== m_valid) $display("FAIL order_wait%0d got %0b exp %0b", i, rs.out_valid, m_valid); else n_pass++;
      if (rs.out_valid) got.push_back(rs.out_rb_index);
    end
    n_checks++; if (got.size() != EXP_EARLY) $display("FAIL order_early got %0d exp %0d", got.size(), EXP_EARLY); else n_pass++;
    cdb_valid[1] = 1'b1; cdb_data[1*W +: W] = 32'h300;
    tick(); cdb_valid = '0;
    if (rs.out_valid) got.push_back(rs.out_rb_index);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rs.out_valid) got.push_back(rs.out_rb_index);
    end
    n_checks++; if (got.size() != 2) $display("FAIL order_total got %0d exp 2", got.size()); else n_pass++;
    if (got.size() == 2) begin
      n_checks++; if (got[0] !== EXP_FIRST) $display("FAIL order_first got %0h exp %0h", got[0], EXP_FIRST); else n_pass++;
    end
  endtask

  task automatic test_flush();
    rs.out_ready = 1'b1;
    // tags outside the CDB range never resolve
    issue(4'd4, 32'h1, 32'h2, 32'h3, READY, 4'd12, READY);
    tick(); idle();
    cdb_valid = '1;
    for (int n = 0; n < RS; n++) cdb_data[n*W +: W] = $urandom;
    repeat (3) tick();
    cdb_valid = '0;
    n_checks++; if (rs.out_valid !== 1'b0 || count !== 3'd1) $display("FAIL oor_tag got v=%0b count=%0d exp 0 1", rs.out_valid, count); else n_pass++;
    for (int kind = 0; kind < 2; kind++) begin
      flush = 1'b1; tick(); flush = 1'b0;
      rs.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
        issue(RI'(i + 1), $urandom, $urandom, $urandom, READY, READY, READY);
        tick();
      end
      n_checks++; if (count !== 3'd3 || rs.out_valid !== 1'b1) $display("FAIL clr%0d_pre got count=%0d v=%0b exp 3 1", kind, count, rs.out_valid); else n_pass++;
      if (kind == 0) flush = 1'b1; else reset = 1'b0;
      issue(4'd8, 32'h5, 32'h6, 32'h7, READY, READY, READY);
      tick();
      flush = 1'b0; reset = 1'b1; idle();
      n_checks++; if (count !== 3'd0) $display("FAIL clr%0d_count got %0d exp 0", kind, count); else n_pass++;
      n_checks++; if (rs.out_valid !== 1'b0) $display("FAIL clr%0d_valid got %0b exp 0", kind, rs.out_valid); else n_pass++;
      n_checks++; if (rs.out_rb_index !== READY) $display("FAIL clr%0d_rb got %0h exp %0h", kind, rs.out_rb_index, READY); else n_pass++;
      n_checks++; if (rs.issue_ready !== 1'b1) $display("FAIL clr%0d_issue_ready got %0b exp 1", kind, rs.issue_ready); else n_pass++;
      tick();
      n_checks++; if (count !== 3'd0 || rs.out_valid !== 1'b0) $display("FAIL clr%0d_dropped got count=%0d v=%0b exp 0 0", kind, count, rs.out_valid); else n_pass++;
    end
    rs.out_ready = 1'b1;
  endtask

  task automatic test_random();
    int budget;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) != 0)
        issue(RI'($urandom_range(0, RS - 1)), $urandom, $urandom, $urandom, rand_tag(), rand_tag(), rand_tag());
      else idle();
      cdb_valid = RS'($urandom & $urandom);
      for (int n = 0; n < RS; n++) cdb_data[n*W +: W] = $urandom;
      rs.out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 63) == 0);
      tick();
      n_checks++; if (rs.out_valid !== m_valid) $display("FAIL rand_valid c=%0d got %0b exp %0b", c, rs.out_valid, m_valid); else n_pass++;
      n_checks++; if (count !== 3'(mq.size())) $display("FAIL rand_count c=%0d got %0d exp %0d", c, count, mq.size()); else n_pass++;
      n_checks++; if (rs.issue_ready !== (mq.size() != DEPTH)) $display("FAIL rand_issue_ready c=%0d got %0b", c, rs.issue_ready); else n_pass++;
      if (m_valid) begin
        n_checks++;
        if (rs.out_addr !== m_addr || rs.out_data !== m_data || rs.out_rb_index !== m_rb)
          $display("FAIL rand_payload c=%0d got %0h/%0h/%0h exp %0h/%0h/%0h", c, rs.out_addr, rs.out_data, rs.out_rb_index, m_addr, m_data, m_rb);
        else n_pass++;
      end
    end
    flush = 1'b0; idle(); rs.out_ready = 1'b1; cdb_valid = '1;
    budget = 40;
    while ((mq.size() != 0 || m_valid) && budget > 0) begin
      tick();
      n_checks++;
      if (rs.out_valid !== m_valid || (m_valid && rs.out_rb_index !== m_rb))
        $display("FAIL rand_drain got v=%0b rb=%0h exp v=%0b rb=%0h", rs.out_valid, rs.out_rb_index, m_valid, m_rb);
      else n_pass++;
      budget--;
    end
    cdb_valid = '0;
    n_checks++; if (count !== 3'd0 || rs.out_valid !== 1'b0) $display("FAIL rand_final got count=%0d v=%0b exp 0 0", count, rs.out_valid); else n_pass++;
  endtask

  initial begin
    idle();
    rs.issue_rb_index = '0; rs.issue_vi = '0; rs.issue_vj = '0; rs.issue_vk = '0;
    rs.issue_qi = READY; rs.issue_qj = READY; rs.issue_qk = READY;
    rs.out_ready = 1'b1;
    test_reset();
    test_all_ready();
    test_cdb_pending();
    test_issue_capture();
    test_full_stall();
    test_in_order();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
